// File: rtl/axi_10g_ethernet_0_tx_arbiter.sv
// Packet-atomic arbiter sharing the 64-bit AXI-Stream MAC TX path between the
// ARP reply, ICMP reply and UDP transmit sources, with per-source frame counters.
module axi_10g_ethernet_0_tx_arbiter #(
  parameter int unsigned PRIORITY_MODE = 0
) (
  input  logic        aclk,
  input  logic        aresetn,

  input  logic [63:0] arp_reply_tdata,
  input  logic [7:0]  arp_reply_tkeep,
  input  logic        arp_reply_tvalid,
  input  logic        arp_reply_tlast,
  output logic        arp_reply_tready,

  input  logic [63:0] icmp_reply_tdata,
  input  logic [7:0]  icmp_reply_tkeep,
  input  logic        icmp_reply_tvalid,
  input  logic        icmp_reply_tlast,
  output logic        icmp_reply_tready,

  input  logic [63:0] udp_tx_tdata,
  input  logic [7:0]  udp_tx_tkeep,
  input  logic        udp_tx_tvalid,
  input  logic        udp_tx_tlast,
  output logic        udp_tx_tready,

  output logic [63:0] tx_axis_tdata,
  output logic [7:0]  tx_axis_tkeep,
  output logic        tx_axis_tvalid,
  output logic        tx_axis_tlast,
  input  logic        tx_axis_tready,

  output logic        tx_busy,
  output logic [1:0]  tx_grant,
  output logic [15:0] arp_pkt_cnt,
  output logic [15:0] icmp_pkt_cnt,
  output logic [15:0] udp_pkt_cnt
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;

  localparam logic [1:0] GrNone = 2'd0;
  localparam logic [1:0] GrArp  = 2'd1;
  localparam logic [1:0] GrIcmp = 2'd2;
  localparam logic [1:0] GrUdp  = 2'd3;

  logic [0:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  winner;
  logic [15:0] arp_cnt_q, arp_cnt_d;
  logic [15:0] icmp_cnt_q, icmp_cnt_d;
  logic [15:0] udp_cnt_q, udp_cnt_d;
  logic        frame_done;

  // Round-robin search starts at the source after the one served last.
  always_comb begin
    winner = GrNone;
    if (PRIORITY_MODE != 0) begin
      if (arp_reply_tvalid)       winner = GrArp;
      else if (icmp_reply_tvalid) winner = GrIcmp;
      else if (udp_tx_tvalid)     winner = GrUdp;
    end else begin
      case (rr_ptr_q)
        GrArp: begin
          if (icmp_reply_tvalid)     winner = GrIcmp;
          else if (udp_tx_tvalid)    winner = GrUdp;
          else if (arp_reply_tvalid) winner = GrArp;
        end
        GrIcmp: begin
          if (udp_tx_tvalid)          winner = GrUdp;
          else if (arp_reply_tvalid)  winner = GrArp;
          else if (icmp_reply_tvalid) winner = GrIcmp;
        end
        default: begin
          if (arp_reply_tvalid)       winner = GrArp;
          else if (icmp_reply_tvalid) winner = GrIcmp;
          else if (udp_tx_tvalid)     winner = GrUdp;
        end
      endcase
    end
  end

  // Zero-cycle pass-through of the granted source while sending.
  always_comb begin
    tx_axis_tdata     = '0;
    tx_axis_tkeep     = '0;
    tx_axis_tvalid    = 1'b0;
    tx_axis_tlast     = 1'b0;
    arp_reply_tready  = 1'b0;
    icmp_reply_tready = 1'b0;
    udp_tx_tready     = 1'b0;
    if (state_q == StSend) begin
      case (grant_q)
        GrArp: begin
          tx_axis_tdata    = arp_reply_tdata;
          tx_axis_tkeep    = arp_reply_tkeep;
          tx_axis_tvalid   = arp_reply_tvalid;
          tx_axis_tlast    = arp_reply_tlast;
          arp_reply_tready = tx_axis_tready;
        end
        GrIcmp: begin
          tx_axis_tdata     = icmp_reply_tdata;
          tx_axis_tkeep     = icmp_reply_tkeep;
          tx_axis_tvalid    = icmp_reply_tvalid;
          tx_axis_tlast     = icmp_reply_tlast;
          icmp_reply_tready = tx_axis_tready;
        end
        GrUdp: begin
          tx_axis_tdata  = udp_tx_tdata;
          tx_axis_tkeep  = udp_tx_tkeep;
          tx_axis_tvalid = udp_tx_tvalid;
          tx_axis_tlast  = udp_tx_tlast;
          udp_tx_tready  = tx_axis_tready;
        end
        default: ;
      endcase
    end
  end

  assign frame_done = (state_q == StSend) & tx_axis_tvalid & tx_axis_tready & tx_axis_tlast;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    arp_cnt_d  = arp_cnt_q;
    icmp_cnt_d = icmp_cnt_q;
    udp_cnt_d  = udp_cnt_q;
    case (state_q)
      StIdle: begin
        if (winner != GrNone) begin
          grant_d = winner;
          state_d = StSend;
        end
      end
      default: begin
        if (frame_done) begin
          state_d  = StIdle;
          grant_d  = GrNone;
          rr_ptr_d = grant_q;
          case (grant_q)
            GrArp:   arp_cnt_d  = arp_cnt_q + 16'd1;
            GrIcmp:  icmp_cnt_d = icmp_cnt_q + 16'd1;
            GrUdp:   udp_cnt_d  = udp_cnt_q + 16'd1;
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      grant_q    <= GrNone;
      rr_ptr_q   <= GrUdp;
      arp_cnt_q  <= '0;
      icmp_cnt_q <= '0;
      udp_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      arp_cnt_q  <= arp_cnt_d;
      icmp_cnt_q <= icmp_cnt_d;
      udp_cnt_q  <= udp_cnt_d;
    end
  end

  assign tx_busy      = (state_q == StSend);
  assign tx_grant     = grant_q;
  assign arp_pkt_cnt  = arp_cnt_q;
  assign icmp_pkt_cnt = icmp_cnt_q;
  assign udp_pkt_cnt  = udp_cnt_q;

endmodule

// File: tb/tb_axi_10g_ethernet_0_tx_arbiter.sv
// Scoreboard bench for the TX arbiter: a round-robin and a fixed-priority instance
// share the source stimulus; a mux selects which one the driver and monitor see.
module tb_axi_10g_ethernet_0_tx_arbiter;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        aresetn;
  logic        sel;
  logic [63:0] s_tdata [3];
  logic [7:0]  s_tkeep [3];
  logic        s_tvalid[3];
  logic        s_tlast [3];
  logic        tx_tready;

  logic        r_tready[2][3];
  logic [63:0] o_tdata [2];
  logic [7:0]  o_tkeep [2];
  logic        o_tvalid[2];
  logic        o_tlast [2];
  logic        o_busy  [2];
  logic [1:0]  o_grant [2];
  logic [15:0] o_cnt   [2][3];

  logic        src_tready[3];
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid, m_tlast, m_busy;
  logic [1:0]  m_grant;
  logic [15:0] cnt[3];

  beat_t      src_q[3][$];
  beat_t      exp_q[3][$];
  logic [1:0] exp_grant[$];
  logic       stall[3];
  logic       hs[3];
  logic       toggle_en;
  int         n_tests, n_fail, frames;

  axi_10g_ethernet_0_tx_arbiter #(.PRIORITY_MODE(0)) dut_rr (
    .aclk(aclk), .aresetn(aresetn),
    .arp_reply_tdata(s_tdata[0]), .arp_reply_tkeep(s_tkeep[0]),
    .arp_reply_tvalid(s_tvalid[0]), .arp_reply_tlast(s_tlast[0]),
    .arp_reply_tready(r_tready[0][0]),
    .icmp_reply_tdata(s_tdata[1]), .icmp_reply_tkeep(s_tkeep[1]),
    .icmp_reply_tvalid(s_tvalid[1]), .icmp_reply_tlast(s_tlast[1]),
    .icmp_reply_tready(r_tready[0][1]),
    .udp_tx_tdata(s_tdata[2]), .udp_tx_tkeep(s_tkeep[2]),
    .udp_tx_tvalid(s_tvalid[2]), .udp_tx_tlast(s_tlast[2]),
    .udp_tx_tready(r_tready[0][2]),
    .tx_axis_tdata(o_tdata[0]), .tx_axis_tkeep(o_tkeep[0]),
    .tx_axis_tvalid(o_tvalid[0]), .tx_axis_tlast(o_tlast[0]),
    .tx_axis_tready(tx_tready),
    .tx_busy(o_busy[0]), .tx_grant(o_grant[0]),
    .arp_pkt_cnt(o_cnt[0][0]), .icmp_pkt_cnt(o_cnt[0][1]), .udp_pkt_cnt(o_cnt[0][2])
  );

  axi_10g_ethernet_0_tx_arbiter #(.PRIORITY_MODE(1)) dut_fp (
    .aclk(aclk), .aresetn(aresetn),
    .arp_reply_tdata(s_tdata[0]), .arp_reply_tkeep(s_tkeep[0]),
    .arp_reply_tvalid(s_tvalid[0]), .arp_reply_tlast(s_tlast[0]),
    .arp_reply_tready(r_tready[1][0]),
    .icmp_reply_tdata(s_tdata[1]), .icmp_reply_tkeep(s_tkeep[1]),
    .icmp_reply_tvalid(s_tvalid[1]), .icmp_reply_tlast(s_tlast[1]),
    .icmp_reply_tready(r_tready[1][1]),
    .udp_tx_tdata(s_tdata[2]), .udp_tx_tkeep(s_tkeep[2]),
    .udp_tx_tvalid(s_tvalid[2]), .udp_tx_tlast(s_tlast[2]),
    .udp_tx_tready(r_tready[1][2]),
    .tx_axis_tdata(o_tdata[1]), .tx_axis_tkeep(o_tkeep[1]),
    .tx_axis_tvalid(o_tvalid[1]), .tx_axis_tlast(o_tlast[1]),
    .tx_axis_tready(tx_tready),
    .tx_busy(o_busy[1]), .tx_grant(o_grant[1]),
    .arp_pkt_cnt(o_cnt[1][0]), .icmp_pkt_cnt(o_cnt[1][1]), .udp_pkt_cnt(o_cnt[1][2])
  );

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      src_tready[i] = r_tready[sel][i];
      cnt[i]        = o_cnt[sel][i];
    end
    m_tdata  = o_tdata[sel];
    m_tkeep  = o_tkeep[sel];
    m_tvalid = o_tvalid[sel];
    m_tlast  = o_tlast[sel];
    m_busy   = o_busy[sel];
    m_grant  = o_grant[sel];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input int s, input int n, input logic [7:0] last_keep);
    beat_t x;
    for (int b = 0; b < n; b++) begin
      x.d = {$urandom, $urandom};
      x.k = (b == n - 1) ? last_keep : 8'hFF;
      x.l = (b == n - 1);
      src_q[s].push_back(x);
      exp_q[s].push_back(x);
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < 3; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      stall[i] = 1'b0;
    end
    exp_grant.delete();
  endtask

  task automatic do_reset();
    aresetn   = 1'b0;
    clear_queues();
    toggle_en = 1'b0;
    tx_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b1;
  endtask

  // Polls after each rising edge until the monitor has seen `target` frames.
  task automatic wait_frames(input int target, input int budget, output int cyc);
    cyc = 0;
    while (frames < target && cyc < budget) begin
      @(posedge aclk);
      #2;
      cyc++;
    end
    if (frames < target) check("frame_timeout", 64'(frames), 64'(target));
  endtask

  // Source driver: present the head beat, retire it after an observed handshake.
  initial begin
    beat_t b;
    for (int i = 0; i < 3; i++) begin
      s_tdata[i] = '0; s_tkeep[i] = '0; s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0;
    end
    forever begin
      @(posedge aclk);
      #1;
      if (toggle_en) tx_tready = ~tx_tready;
      for (int i = 0; i < 3; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0 && !stall[i]) begin
          b           = src_q[i][0];
          s_tvalid[i] = 1'b1;
          s_tdata[i]  = b.d;
          s_tkeep[i]  = b.k;
          s_tlast[i]  = b.l;
        end else begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard on the falling edge.
  initial begin
    bit    first, after_last;
    int    gi;
    beat_t e;
    logic [1:0] eg;
    first = 1'b1;
    after_last = 1'b0;
    forever begin
      @(negedge aclk);
      for (int i = 0; i < 3; i++) hs[i] = s_tvalid[i] && src_tready[i];
      if (!aresetn) begin
        first = 1'b1;
        after_last = 1'b0;
      end else begin
        if (after_last) begin
          check("gap_busy", m_busy, 0);
          check("gap_grant", m_grant, 0);
          check("gap_valid", m_tvalid, 0);
          after_last = 1'b0;
        end
        if (m_tvalid) begin
          check("grant_nonzero", m_grant != 2'd0, 1);
          gi = int'(m_grant) - 1;
          if (gi >= 0) begin
            for (int i = 0; i < 3; i++)
              check("ready_route", src_tready[i], (i == gi) ? tx_tready : 1'b0);
            if (exp_q[gi].size() == 0) begin
              check("beat_expected", 0, 1);
            end else begin
              e = exp_q[gi][0];
              check("tdata", m_tdata, e.d);
              check("tkeep", m_tkeep, e.k);
              check("tlast", m_tlast, e.l);
              if (tx_tready) begin
                void'(exp_q[gi].pop_front());
                if (first) begin
                  if (exp_grant.size() == 0) begin
                    check("grant_expected", 0, 1);
                  end else begin
                    eg = exp_grant.pop_front();
                    check("grant_seq", m_grant, eg);
                  end
                  first = 1'b0;
                end
                if (m_tlast) begin
                  first = 1'b1;
                  after_last = 1'b1;
                  frames++;
                end
              end
            end
          end
        end
      end
    end
  end

  initial begin
    int base, cyc;
    n_tests = 0; n_fail = 0; frames = 0;
    sel = 1'b0; tx_tready = 1'b1; toggle_en = 1'b0;
    for (int i = 0; i < 3; i++) begin stall[i] = 1'b0; hs[i] = 1'b0; end
    aresetn = 1'b1;
    #2 aresetn = 1'b0;
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_grant", m_grant, 0);
    check("rst_busy", m_busy, 0);
    for (int i = 0; i < 3; i++) check("rst_src_tready", src_tready[i], 0);
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b1;
    for (int i = 0; i < 3; i++) check("rst_cnt", cnt[i], 0);

    // Single 3-beat ICMP frame with one-cycle grant latency.
    base = frames;
    push_frame(1, 3, 8'h0F);
    exp_grant.push_back(2'd2);
    @(negedge aclk);
    @(negedge aclk);
    check("lat_src_valid", s_tvalid[1], 1);
    check("lat_idle_valid", m_tvalid, 0);
    @(negedge aclk);
    check("lat_out_valid", m_tvalid, 1);
    check("lat_grant", m_grant, 2);
    check("lat_busy", m_busy, 1);
    wait_frames(base + 1, 20, cyc);
    check("icmp_cnt", cnt[1], 1);
    check("icmp_grant_after", m_grant, 0);
    check("icmp_busy_after", m_busy, 0);

    // Round robin with all sources requesting 2-beat frames.
    do_reset();
    base = frames;
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < 3; s++) begin
        push_frame(s, 2, 8'hFF);
        exp_grant.push_back(2'(s + 1));
      end
    wait_frames(base + 6, 100, cyc);
    check("rr_cycles", cyc, 19);
    for (int i = 0; i < 3; i++) check("rr_cnt", cnt[i], 2);

    // Backpressure: MAC ready toggles every cycle during a 4-beat UDP frame.
    do_reset();
    base = frames;
    push_frame(2, 4, 8'hFF);
    exp_grant.push_back(2'd3);
    tx_tready = 1'b0;
    toggle_en = 1'b1;
    wait_frames(base + 1, 40, cyc);
    check("bp_cycles", cyc, 10);
    check("bp_udp_cnt", cnt[2], 1);
    toggle_en = 1'b0;
    tx_tready = 1'b1;

    // UDP stalls mid-frame; ARP must wait for UDP tlast.
    do_reset();
    base = frames;
    push_frame(2, 4, 8'hFF);
    exp_grant.push_back(2'd3);
    repeat (2) @(posedge aclk);
    #2;
    stall[2] = 1'b1;
    push_frame(0, 1, 8'hFF);
    exp_grant.push_back(2'd1);
    repeat (5) begin
      @(posedge aclk);
      #2;
      check("stall_grant", m_grant, 3);
      check("stall_busy", m_busy, 1);
      check("stall_arp_blocked", src_tready[0], 0);
    end
    stall[2] = 1'b0;
    wait_frames(base + 2, 40, cyc);
    check("stall_udp_cnt", cnt[2], 1);
    check("stall_arp_cnt", cnt[0], 1);

    // Back-to-back single-beat ICMP frames from one source.
    do_reset();
    base = frames;
    for (int f = 0; f < 200; f++) begin
      push_frame(1, 1, 8'hFF);
      exp_grant.push_back(2'd2);
    end
    wait_frames(base + 200, 1000, cyc);
    check("burst_cycles", cyc, 401);
    check("burst_icmp_cnt", cnt[1], 200);

    // Fixed priority: ARP starves ICMP/UDP while it keeps requesting.
    sel = 1'b1;
    do_reset();
    base = frames;
    for (int f = 0; f < 4; f++) begin
      push_frame(0, 2, 8'hFF);
      exp_grant.push_back(2'd1);
    end
    push_frame(1, 2, 8'hFF);
    push_frame(2, 2, 8'hFF);
    exp_grant.push_back(2'd2);
    exp_grant.push_back(2'd3);
    wait_frames(base + 4, 60, cyc);
    check("fp_cycles", cyc, 13);
    check("fp_arp_cnt", cnt[0], 4);
    check("fp_icmp_cnt", cnt[1], 0);
    check("fp_udp_cnt", cnt[2], 0);
    wait_frames(base + 6, 60, cyc);
    check("fp_icmp_cnt_end", cnt[1], 1);
    check("fp_udp_cnt_end", cnt[2], 1);

    // Asynchronous reset on beat 2 of a 4-beat ARP frame.
    base = frames;
    push_frame(0, 4, 8'hFF);
    exp_grant.push_back(2'd1);
    repeat (3) @(posedge aclk);
    #2;
    check("mid_valid_before", m_tvalid, 1);
    aresetn = 1'b0;
    #1;
    check("mid_valid_async", m_tvalid, 0);
    check("mid_tlast_async", m_tlast, 0);
    for (int i = 0; i < 3; i++) check("mid_src_tready", src_tready[i], 0);
    clear_queues();
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b1;
    for (int i = 0; i < 3; i++) check("mid_cnt", cnt[i], 0);
    check("mid_grant", m_grant, 0);
    check("mid_busy", m_busy, 0);
    base = frames;
    push_frame(0, 3, 8'hFF);
    exp_grant.push_back(2'd1);
    wait_frames(base + 1, 20, cyc);
    check("mid_new_arp_cnt", cnt[0], 1);

    repeat (2) @(posedge aclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_10g_ethernet_0_tx_arbiter.md
# axi_10g_ethernet_0_tx_arbiter

Packet-atomic arbiter that shares the single 64-bit AXI-Stream TX path into the 10G Ethernet MAC between three frame sources: ARP reply, ICMP reply and UDP transmit. It sits between the protocol generators and the MAC TX interface. It grants one source at a time, passes that source's frame through unmodified, and releases the path only after the frame's tlast beat is accepted. Round-robin or fixed-priority selection is chosen by parameter; per-source frame counters are provided for debug.

## Interface
- PRIORITY_MODE, 0, 0 = round-robin among ARP/ICMP/UDP; 1 = fixed priority ARP > ICMP > UDP
- aclk  in  1  TX clock; all logic on its rising edge
- aresetn  in  1  asynchronous, active-low reset
- arp_reply_tdata / icmp_reply_tdata / udp_tx_tdata  in  64  source data, one bus per source
- arp_reply_tkeep / icmp_reply_tkeep / udp_tx_tkeep  in  8  byte enables
- arp_reply_tvalid / icmp_reply_tvalid / udp_tx_tvalid  in  1  source valid; a rising request when idle
- arp_reply_tlast / icmp_reply_tlast / udp_tx_tlast  in  1  last beat of frame
- arp_reply_tready / icmp_reply_tready / udp_tx_tready  out  1  source ready
- tx_axis_tdata  out  64  to MAC
- tx_axis_tkeep  out  8  to MAC
- tx_axis_tvalid  out  1  to MAC
- tx_axis_tlast  out  1  to MAC
- tx_axis_tready  in  1  from MAC
- tx_busy  out  1  high while in SEND
- tx_grant  out  2  0 = none, 1 = ARP, 2 = ICMP, 3 = UDP (registered)
- arp_pkt_cnt / icmp_pkt_cnt / udp_pkt_cnt  out  16  completed frames per source, wrap at 16'hFFFF -> 0

## Operation
- States: IDLE, SEND.
- **IDLE:**
  - All source treadys are 0 and tx_axis_tvalid is 0.
  - If any source tvalid is 1, select a winner, register it into tx_grant and go to SEND.
  - If no source is valid, stay in IDLE.
- **Selection in round-robin mode:**
  - Search order starts at the source after rr_ptr.
  - rr_ptr resets to UDP, so the first search order is ARP, ICMP, UDP.
  - On frame completion, rr_ptr takes the value of the source just served.
- **Selection in fixed mode:** ARP first, then ICMP, then UDP; rr_ptr is ignored.
- **SEND (combinational pass-through from the granted source):**
  - tx_axis_{tdata,tkeep,tlast,tvalid} equal the granted source's signals.
  - The granted source's tready equals tx_axis_tready.
  - Non-granted treadys are 0.
  - tdata and tkeep pass unmodified.
- **Frame end:** on a beat with tx_axis_tvalid & tx_axis_tready & tx_axis_tlast:
  - increment the granted source's counter;
  - update rr_ptr;
  - clear tx_grant to 0;
  - go to IDLE.
- **Mid-frame behaviour:**
  - A granted source may drop tvalid mid-frame. The grant holds indefinitely; there is no timeout and no interleaving.
  - Requests from other sources during SEND are ignored until the frame ends.
- Counters are plain 16-bit wrapping incrementers.

## Timing
- **Reset values:** state = IDLE, tx_grant = 0, tx_busy = 0, rr_ptr = UDP, all counters = 0.
- **Asynchronous reset effect:** while aresetn = 0, tx_axis_tvalid = 0, tx_axis_tlast = 0 and every source tready = 0, immediately and independent of aclk.
- **Reset mid-frame:** the frame is truncated with no tlast. After release the arbiter starts in IDLE; the source is responsible for restarting its frame.
- **Latency:** a source tvalid asserted in an IDLE cycle gives tx_axis_tvalid = 1 and that source's tready = tx_axis_tready in the next cycle.
- **Inter-frame gap:** exactly one IDLE bubble cycle after every tlast beat, including back-to-back frames from the same source.
- Zero-cycle pass-through of data, valid, last and ready while in SEND.
- **Single-beat frame:** tlast on the first beat gives one SEND cycle (given tready = 1), then IDLE.
- **Backpressure:** tx_axis_tready = 0 holds all outputs stable. The source must hold its data, as AXI-Stream requires.
- **Simultaneous requests:**
  - Resolved only in IDLE, using the rr_ptr value current in that cycle.
  - A source that raises tvalid in the cycle its competitor's tlast completes is considered in the following IDLE cycle.

## Test plan
- **Single ICMP frame:** 3 beats, tkeep 8'hFF, 8'hFF, 8'h0F, with tx_axis_tready = 1. Required response:
  - tx_axis output appears one cycle after icmp_reply_tvalid, with identical data;
  - tx_grant = 2 during the frame;
  - icmp_pkt_cnt = 1;
  - tx_grant = 0 in the cycle after tlast.
- **All three sources request continuously, PRIORITY_MODE = 0, each with 2-beat frames:** grant sequence is ARP, ICMP, UDP, ARP, …, with one idle cycle between frames. After 6 frames each counter = 2.
- **Same stimulus with PRIORITY_MODE = 1:** only ARP is served while it keeps requesting. After 4 frames arp_pkt_cnt = 4 and icmp/udp counters = 0.
- **Backpressure and stall:**
  - Toggling tx_axis_tready 1/0 every cycle during a 4-beat UDP frame: udp_tx_tready mirrors tx_axis_tready, there is no data loss, and the frame completes in 8 cycles.
  - udp_tx_tvalid dropped for 5 cycles mid-frame: the grant stays at 3 and an ARP request is not served until UDP tlast.
- **Reset mid-frame:** assert aresetn = 0 on beat 2 of a 4-beat ARP frame. Required response:
  - tx_axis_tvalid falls without a clock edge;
  - after release, counters = 0 and tx_grant = 0;
  - a new ARP frame is forwarded normally.
- **Counter wrap:** drive 65 536 single-beat ICMP frames. icmp_pkt_cnt returns to 0 and tx_busy shows one idle cycle between frames.
